// File: rtl/sn_tile_receiver.sv
// sn_tile_receiver: tile-side endpoint of the signaling ring message protocol.
// Accepts a start message addressed to this tile and latches the workload base
// address and byte length. It splits the workload into burst-sized work
// requests, tracks outstanding completions, then raises done for the GC under
// a four-phase handshake (done held until op drops).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   my_tile               this tile's ID (static after reset)
//   op, tile, addr, len   GC message: valid/start, destination, base, bytes
//   done                  workload complete acknowledge to GC
//   req_valid/req_ready   work request handshake toward the work engine
//   req_addr, req_len     request address and byte count (1..BURST_BYTES)
//   cmp_valid             one-cycle pulse per completed request
//   busy                  block is not idle
//   cmp_err               sticky: completion seen with nothing outstanding
module sn_tile_receiver #(
    parameter int unsigned TILE_WIDTH      = 4,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned WL_LEN_BITS     = 32,
    parameter int unsigned BURST_BYTES     = 64,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TILE_WIDTH-1:0]  my_tile,
    input  logic                   op,
    input  logic [TILE_WIDTH-1:0]  tile,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [WL_LEN_BITS-1:0] len,
    output logic                   done,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [ADDR_WIDTH-1:0]  req_addr,
    output logic [WL_LEN_BITS-1:0] req_len,
    input  logic                   cmp_valid,
    output logic                   busy,
    output logic                   cmp_err
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]       MAX_CNT    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [WL_LEN_BITS-1:0] BURST_LEN  = WL_LEN_BITS'(BURST_BYTES);
    localparam logic [ADDR_WIDTH-1:0]  BURST_STEP = ADDR_WIDTH'(BURST_BYTES);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StAck} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
    logic [WL_LEN_BITS-1:0] remain_q, remain_d;
    logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
    logic                   cmp_err_q, cmp_err_d;

    logic [WL_LEN_BITS-1:0] burst_len;
    logic                   accept;
    logic                   cmp_ok;

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        cmp_err_d  = cmp_err_q;

        burst_len = (remain_q < BURST_LEN) ? remain_q : BURST_LEN;

        // Issue gating uses only registered state so it never depends on req_ready.
        req_valid = (state_q == StIssue) && (out_cnt_q < MAX_CNT);
        req_addr  = (state_q == StIssue) ? cur_addr_q : '0;
        req_len   = (state_q == StIssue) ? burst_len : '0;
        done      = (state_q == StAck);
        busy      = (state_q != StIdle);
        cmp_err   = cmp_err_q;

        accept = req_valid && req_ready;
        // A completion with nothing outstanding is flagged, not counted.
        cmp_ok = cmp_valid && (out_cnt_q != '0);
        if (cmp_valid && (out_cnt_q == '0)) begin
            cmp_err_d = 1'b1;
        end
        out_cnt_d = out_cnt_q + CNT_W'(accept) - CNT_W'(cmp_ok);

        unique case (state_q)
            StIdle: begin
                if (op && (tile == my_tile)) begin
                    cur_addr_d = addr;
                    remain_d   = len;
                    state_d    = (len == '0) ? StAck : StIssue;
                end
            end
            StIssue: begin
                if (accept) begin
                    cur_addr_d = cur_addr_q + BURST_STEP;
                    remain_d   = remain_q - burst_len;
                    if (remain_q == burst_len) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_cnt_q == '0) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                if (!op) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cur_addr_q <= '0;
            remain_q   <= '0;
            out_cnt_q  <= '0;
            cmp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            remain_q   <= remain_d;
            out_cnt_q  <= out_cnt_d;
            cmp_err_q  <= cmp_err_d;
        end
    end

endmodule

// File: tb/tb_sn_tile_receiver.sv
module tb_sn_tile_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  my_tile = 4'd2;
    logic        op = 1'b0;
    logic [3:0]  tile = 4'd0;
    logic [63:0] addr = 64'd0;
    logic [31:0] len = 32'd0;
    logic        done;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [63:0] req_addr;
    logic [31:0] req_len;
    logic        cmp_valid = 1'b0;
    logic        busy;
    logic        cmp_err;

    sn_tile_receiver #(
        .TILE_WIDTH     (4),
        .ADDR_WIDTH     (64),
        .WL_LEN_BITS    (32),
        .BURST_BYTES    (64),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .my_tile  (my_tile),
        .op       (op),
        .tile     (tile),
        .addr     (addr),
        .len      (len),
        .done     (done),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_len  (req_len),
        .cmp_valid(cmp_valid),
        .busy     (busy),
        .cmp_err  (cmp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [31:0] l;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_accept = 0;
    logic fire_last = 1'b0;
    logic auto_cmp = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference split of a workload into bursts of at most 64 bytes.
    task automatic push_work(input logic [63:0] a, input logic [31:0] l);
        logic [31:0] rem = l;
        logic [63:0] cur = a;
        exp_t e;
        while (rem != 0) begin
            e.a = cur;
            e.l = (rem < 32'd64) ? rem : 32'd64;
            exp_q.push_back(e);
            cur = cur + 64'd64;
            rem = rem - e.l;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_cmp) cmp_valid = fire_last;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard: every accepted request is compared against the model queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && req_valid && req_ready) begin
            n_accept++;
            fire_last = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_req", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("req_addr", req_addr, e.a);
                check("req_len", {32'd0, req_len}, {32'd0, e.l});
            end
        end else begin
            fire_last = 1'b0;
        end
    end

    initial begin
        int lat;
        int quiet;
        int base;

        // Reset state
        do_reset();
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_req_valid", {63'd0, req_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_cmp_err", {63'd0, cmp_err}, 64'd0);
        check("rst_req_addr", req_addr, 64'd0);
        check("rst_req_len", {32'd0, req_len}, 64'd0);

        // Basic workload: 200 bytes, completion one cycle after each accept
        auto_cmp = 1'b1;
        req_ready = 1'b1;
        push_work(64'h1000, 32'd200);
        op = 1'b1; tile = 4'd2; addr = 64'h1000; len = 32'd200;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done && lat == 0) lat = i;
        end
        check("basic_done_latency", 64'(lat), 64'd7);
        check("basic_accepts", 64'(n_accept), 64'd4);
        check("basic_queue_empty", 64'(exp_q.size()), 64'd0);
        check("basic_done_held", {63'd0, done}, 64'd1);
        op = 1'b0;
        tick();
        check("basic_done_release", {63'd0, done}, 64'd0);
        check("basic_idle", {63'd0, busy}, 64'd0);

        // Message for another tile is ignored
        auto_cmp = 1'b0;
        my_tile = 4'd3;
        do_reset();
        op = 1'b1; tile = 4'd5; addr = 64'h4000; len = 32'd64;
        quiet = 0;
        base = n_accept;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_valid || done || busy) quiet++;
        end
        check("nomatch_quiet", 64'(quiet), 64'd0);
        check("nomatch_accepts", 64'(n_accept - base), 64'd0);
        op = 1'b0;

        // Zero-length workload acknowledges immediately
        my_tile = 4'd2;
        do_reset();
        base = n_accept;
        op = 1'b1; tile = 4'd2; addr = 64'h5000; len = 32'd0;
        tick();
        check("zero_done", {63'd0, done}, 64'd1);
        check("zero_no_req", {63'd0, req_valid}, 64'd0);
        op = 1'b0;
        tick();
        check("zero_release", {63'd0, done}, 64'd0);
        check("zero_accepts", 64'(n_accept - base), 64'd0);

        // Outstanding limit of 2 with no completions
        base = n_accept;
        push_work(64'h2000, 32'd256);
        op = 1'b1; tile = 4'd2; addr = 64'h2000; len = 32'd256;
        tick();
        tick();
        tick();
        check("limit_stall", {63'd0, req_valid}, 64'd0);
        tick();
        tick();
        check("limit_accepts", 64'(n_accept - base), 64'd2);
        cmp_valid = 1'b1;
        tick();
        cmp_valid = 1'b0;
        check("limit_resume", {63'd0, req_valid}, 64'd1);
        cmp_valid = 1'b1;
        tick();
        cmp_valid = 1'b0;
        check("limit_same_cycle_cnt", 64'(dut.out_cnt_q), 64'd1);
        tick();
        check("limit_accepts_all", 64'(n_accept - base), 64'd4);
        check("limit_drain_busy", {63'd0, busy}, 64'd1);
        cmp_valid = 1'b1;
        tick();
        tick();
        cmp_valid = 1'b0;
        check("limit_done_not_yet", {63'd0, done}, 64'd0);
        tick();
        check("limit_done", {63'd0, done}, 64'd1);
        check("limit_queue_empty", 64'(exp_q.size()), 64'd0);
        check("limit_no_err", {63'd0, cmp_err}, 64'd0);
        op = 1'b0;
        tick();
        check("limit_release", {63'd0, done}, 64'd0);

        // Stray completion in IDLE sets sticky error
        cmp_valid = 1'b1;
        tick();
        cmp_valid = 1'b0;
        check("err_set", {63'd0, cmp_err}, 64'd1);
        tick();
        tick();
        check("err_sticky", {63'd0, cmp_err}, 64'd1);
        do_reset();
        check("err_cleared", {63'd0, cmp_err}, 64'd0);

        // Reset mid-ISSUE, message re-accepted afterwards
        exp_q.push_back('{a: 64'h3000, l: 32'd64});
        base = n_accept;
        op = 1'b1; tile = 4'd2; addr = 64'h3000; len = 32'd256;
        tick();
        tick();
        check("midrst_one_accept", 64'(n_accept - base), 64'd1);
        req_ready = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_req_valid", {63'd0, req_valid}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_req_addr", req_addr, 64'd0);
        rst = 1'b0;
        req_ready = 1'b1;
        auto_cmp = 1'b1;
        push_work(64'h3000, 32'd256);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done && lat == 0) lat = i;
        end
        check("midrst_done_seen", {63'd0, (lat != 0)}, 64'd1);
        check("midrst_queue_empty", 64'(exp_q.size()), 64'd0);
        check("midrst_accepts", 64'(n_accept - base), 64'd5);
        op = 1'b0;
        tick();
        check("midrst_release", {63'd0, done}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sn_tile_receiver.md
# sn_tile_receiver

Tile-side endpoint of the signaling ring message protocol; the GC FSM is the sender on the other end. When a start message addressed to this tile is presented, the block latches the workload base address and byte length, splits it into burst-sized work requests toward the tile's local work engine, and tracks completions. It then returns `done` under a four-phase handshake with the GC.

## Interface
- `TILE_WIDTH`, 4, width of tile ID
- `ADDR_WIDTH`, 64, workload address width
- `WL_LEN_BITS`, 32, workload length width (bytes)
- `BURST_BYTES`, 64, max bytes per work request (power of two)
- `MAX_OUTSTANDING`, 8, max issued-but-uncompleted requests (≥1)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `my_tile`  in  TILE_WIDTH  this tile's ID, static after reset
- `op`  in  1  GC message valid / start; held until `done` seen
- `tile`  in  TILE_WIDTH  destination tile of message
- `addr`  in  ADDR_WIDTH  workload base address
- `len`  in  WL_LEN_BITS  workload length in bytes
- `done`  out  1  workload complete acknowledge to GC
- `req_valid`  out  1  work request valid
- `req_ready`  in  1  work engine accepts request
- `req_addr`  out  ADDR_WIDTH  request address
- `req_len`  out  WL_LEN_BITS  request bytes, 1..BURST_BYTES
- `cmp_valid`  in  1  one-cycle pulse, one request completed
- `busy`  out  1  state != IDLE
- `cmp_err`  out  1  sticky: completion received with zero outstanding

## Operation
- States: IDLE, ISSUE, DRAIN, ACK.
- IDLE: if `op && tile==my_tile`, latch `cur_addr<=addr`, `remain<=len`. If `len==0`, go to ACK; else go to ISSUE. Non-matching or `op==0`: stay, no outputs.
- ISSUE: `req_valid = (out_cnt < MAX_OUTSTANDING)` (combinational from registered state/counter). `req_addr = cur_addr`. `req_len = min(remain, BURST_BYTES)`.
  - On `req_valid && req_ready`: `cur_addr += BURST_BYTES` (mod 2^ADDR_WIDTH), `remain -= req_len`, `out_cnt++`.
  - If the transfer drains `remain` to 0, go to DRAIN.
- DRAIN: `req_valid=0`. Go to ACK when the registered `out_cnt==0`.
- ACK: `done=1` (decoded from state). Stay while `op==1`; when `op==0`, go to IDLE, so `done` falls the next cycle.
- `out_cnt` (width clog2(MAX_OUTSTANDING+1)):
  - `cmp_valid` decrements it in any state.
  - Simultaneous accept and completion: unchanged.
  - `cmp_valid` with `out_cnt==0`: counter unchanged, `cmp_err<=1`. Only `rst` clears `cmp_err`.
- Message fields are sampled only in IDLE. Changes to `tile`/`addr`/`len` during ISSUE/DRAIN/ACK are ignored.
- `op` dropping before ACK: ignored; the workload still completes, and `done` pulses for one cycle in ACK then the block returns to IDLE.

## Timing
- Reset values: `done=0`, `req_valid=0`, `busy=0`, `cmp_err=0`, `req_addr=0`, `req_len=0`, state IDLE, `out_cnt=0`, `remain=0`.
- Message acceptance: message sampled at edge N in IDLE → state ISSUE and `req_valid` high in cycle N+1 (ready-permitting, one request per cycle).
- Zero-length message: `done` high in cycle N+1.
- Last completion in cycle M (DRAIN) → `out_cnt==0` at M+1 → `done` high in M+2.
- Done release: `op` low at edge K in ACK → `done` low in cycle K+1. A new message can be accepted at K+1 at the earliest.
- Reset mid-operation: all state returns to reset values the next cycle, and in-flight completions are not tracked. If `op` is still high and matching after `rst` deasserts, the message is re-accepted.
- `req_valid` never depends combinationally on `req_ready`.

## Test plan
- `my_tile=2`, `op=1 tile=2 addr=0x1000 len=200`, `req_ready=1`, `cmp_valid` one cycle after each accept → requests (0x1000,64), (0x1040,64), (0x1080,64), (0x10C0,8) on consecutive cycles; `done` two cycles after the last completion, held until `op=0`, low one cycle later.
- `my_tile=3`, `op=1 tile=5 len=64` for 20 cycles → `req_valid`, `done`, `busy` stay 0.
- `len=0` matching → no request; `done=1` in the cycle after acceptance.
- `MAX_OUTSTANDING=2`, `len=256`, no completions → exactly 2 accepts, then `req_valid=0`. One `cmp_valid` → third request issued next cycle. Accept and completion in the same cycle → `out_cnt` unchanged.
- `cmp_valid` pulse in IDLE → `cmp_err=1`, which stays 1 until `rst`.
- `rst` asserted during ISSUE after 1 of 4 requests, `op` held matching → outputs reset next cycle; after release the message is re-accepted and the request sequence restarts at `addr`.
